sap_mem_ctrl: RTL and testbench



---
 rtl/sap_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_sap_mem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_mem_ctrl.sv
// SAP-II main-memory controller: ROM+RAM array, wait states, ROM guard.
// Optional per-location even parity when SAP_MEM_PARITY_EN is defined.
`timescale 1ns/1ps
module sap_mem_ctrl #(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] ROM_TOP     = 16'h07FF,
   parameter int unsigned       WAIT_STATES = 1
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              REQ,
   input  logic              WE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] DIN,
   output logic [DATA_W-1:0] DOUT,
   output logic              ACK,
   output logic              BUSY,
   output logic              ROM_ERR,
   output logic              PERR
);

   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam logic [3:0]  WS_LOAD =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACC
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] a_q;
   logic              we_q;
   logic [DATA_W-1:0] d_q;

   // The array holds each word XORed with its power-up value, so an
   // all-zero array reads back as the monitor image (0/1 = 80H, else i).
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

   function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] i);
      logic [DATA_W-1:0] v;
      if (i < ADDR_W'(2))
         v = {1'b1, {(DATA_W-1){1'b0}}};
      else
         v = DATA_W'(i);
      return v;
   endfunction

   logic              acc;
   logic              wr_ram;
   logic [DATA_W-1:0] rd_data;

   assign acc     = (state_q == S_ACC);
   assign wr_ram  = acc && we_q && (a_q > ROM_TOP);
   assign rd_data = mem_q[a_q] ^ dflt(a_q);
   assign BUSY    = (state_q != S_IDLE);

   // State and wait-counter register.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: accept in IDLE, burn wait states, one access cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (REQ) begin
               if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = S_ACC;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0)
               state_d = S_ACC;
            else
               cnt_d = cnt_q - 4'd1;
         end
         S_ACC:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch; later input changes are ignored until the next IDLE.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         a_q  <= '0;
         we_q <= 1'b0;
         d_q  <= '0;
      end else if (state_q == S_IDLE && REQ) begin
         a_q  <= ADDR;
         we_q <= WE;
         d_q  <= DIN;
      end
   end

   // Completion outputs: read data, ACK pulse, sticky ROM violation.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         DOUT    <= '0;
         ACK     <= 1'b0;
         ROM_ERR <= 1'b0;
      end else begin
         ACK <= acc;
         if (acc && !we_q)
            DOUT <= rd_data;
         if (acc && we_q && (a_q <= ROM_TOP))
            ROM_ERR <= 1'b1;
      end
   end

   // Array write; CLR on the access edge suppresses it.
   always_ff @(posedge CLK) begin
      if (!CLR && wr_ram)
         mem_q[a_q] <= d_q ^ dflt(a_q);
   end

`ifdef SAP_MEM_PARITY_EN
   // Parity is stored relative to the power-up word's parity, so the
   // zeroed array starts out consistent.
   logic par_q [DEPTH] = '{default: 1'b0};

   // Parity write alongside the data write.
   always_ff @(posedge CLK) begin
      if (!CLR && wr_ram)
         par_q[a_q] <= (^d_q) ^ (^dflt(a_q));
   end

   // Parity check on reads, flagged for the ACK cycle only.
   always_ff @(posedge CLK) begin
      if (CLR)
         PERR <= 1'b0;
      else
         PERR <= acc && !we_q &&
                 ((par_q[a_q] ^ (^dflt(a_q))) != (^rd_data));
   end
`else
   assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_sap_mem_ctrl.sv
// Randomised self-checking bench for sap_mem_ctrl.
// Two instances: WAIT_STATES=1 (main) and WAIT_STATES=0 (throughput).
`timescale 1ns/1ps
module tb_sap_mem_ctrl;

   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       req = 1'b0, we = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       ack, busy, rom_err, perr;

   logic       req0 = 1'b0, we0 = 1'b0;
   logic [15:0] addr0 = '0;
   logic [7:0] din0 = '0;
   logic [7:0] dout0;
   logic       ack0, busy0, rom_err0, perr0;

   int n_chk = 0;
   int n_fail = 0;
   int perr_cnt = 0;
   int perr_exp = 0;

   logic [7:0] m_ram [logic [15:0]];
   logic [7:0] m_dout = '0;
   logic       m_rom = 1'b0;

   always #5 clk = ~clk;

   sap_mem_ctrl #(.WAIT_STATES(1)) u_dut (
      .CLK(clk), .CLR(clr), .REQ(req), .WE(we), .ADDR(addr), .DIN(din),
      .DOUT(dout), .ACK(ack), .BUSY(busy), .ROM_ERR(rom_err), .PERR(perr)
   );

   sap_mem_ctrl #(.WAIT_STATES(0)) u_dut0 (
      .CLK(clk), .CLR(clr), .REQ(req0), .WE(we0), .ADDR(addr0),
      .DIN(din0), .DOUT(dout0), .ACK(ack0), .BUSY(busy0),
      .ROM_ERR(rom_err0), .PERR(perr0)
   );

   always @(negedge clk) perr_cnt += int'(perr) + int'(perr0);

   function automatic logic [7:0] mdl_rd(input logic [15:0] a);
      if (m_ram.exists(a)) return m_ram[a];
      if (a < 16'd2) return 8'h80;
      return a[7:0];
   endfunction

   function automatic void mdl_wr(input logic [15:0] a,
                                  input logic [7:0] d);
      if (a > 16'h07FF) m_ram[a] = d;
      else m_rom = 1'b1;
   endfunction

   // One access on the main instance; k = negedge index of ACK, -1 if none.
   task automatic xact(input logic w, input logic [15:0] a,
                       input logic [7:0] d, output int k,
                       output logic [7:0] dv, output logic pv);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; din = d;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; we = 1'($urandom);
      addr = 16'($urandom); din = 8'($urandom);
      k = 1;
      while (!ack && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!ack) k = -1;
      dv = dout;
      pv = perr;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      m_dout = '0; m_rom = 1'b0;
      n_chk++; if (dout !== 8'h00) begin n_fail++;
         $display("FAIL rst_dout got=%h exp=00", dout); end
      n_chk++; if (ack !== 1'b0) begin n_fail++;
         $display("FAIL rst_ack got=%b exp=0", ack); end
      n_chk++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL rst_busy got=%b exp=0", busy); end
      n_chk++; if (rom_err !== 1'b0) begin n_fail++;
         $display("FAIL rst_rom_err got=%b exp=0", rom_err); end
      n_chk++; if (perr !== 1'b0) begin n_fail++;
         $display("FAIL rst_perr got=%b exp=0", perr); end
      n_chk++; if ({busy0, ack0, dout0} !== 10'h0) begin n_fail++;
         $display("FAIL rst_dut0 got=%b%b%h exp=0000", busy0, ack0, dout0); end
   endtask

   task automatic test_powerup();
      logic [15:0] al [4] = '{16'h0000, 16'h0002, 16'h1234, 16'h0001};
      int k; logic [7:0] dv; logic pv;
      foreach (al[i]) begin
         xact(1'b0, al[i], 8'h00, k, dv, pv);
         m_dout = mdl_rd(al[i]);
         n_chk++; if (k !== LAT) begin n_fail++;
            $display("FAIL pu_lat a=%h got=%0d exp=%0d", al[i], k, LAT); end
         n_chk++; if (dv !== m_dout) begin n_fail++;
            $display("FAIL pu_data a=%h got=%h exp=%h", al[i], dv, m_dout); end
         @(negedge clk);
         n_chk++; if (ack !== 1'b0) begin n_fail++;
            $display("FAIL pu_ack_pulse a=%h got=%b exp=0", al[i], ack); end
      end
   endtask

   task automatic test_ram_rw();
      logic [15:0] al [2] = '{16'h0803, 16'hFFFF};
      logic [7:0]  dl [2] = '{8'h20, 8'hAB};
      int k; logic [7:0] dv; logic pv;
      foreach (al[i]) begin
         xact(1'b1, al[i], dl[i], k, dv, pv);
         mdl_wr(al[i], dl[i]);
         n_chk++; if (k !== LAT) begin n_fail++;
            $display("FAIL wr_lat a=%h got=%0d exp=%0d", al[i], k, LAT); end
         n_chk++; if (dv !== m_dout) begin n_fail++;
            $display("FAIL wr_dout_hold a=%h got=%h exp=%h", al[i], dv, m_dout); end
         n_chk++; if (rom_err !== 1'b0) begin n_fail++;
            $display("FAIL wr_rom_err a=%h got=%b exp=0", al[i], rom_err); end
         xact(1'b0, al[i], 8'h00, k, dv, pv);
         m_dout = mdl_rd(al[i]);
         n_chk++; if (dv !== m_dout) begin n_fail++;
            $display("FAIL rd_back a=%h got=%h exp=%h", al[i], dv, m_dout); end
      end
   endtask

   task automatic test_rom_protect();
      int k; logic [7:0] dv; logic pv;
      xact(1'b1, 16'h0004, 8'h30, k, dv, pv);
      mdl_wr(16'h0004, 8'h30);
      n_chk++; if (k !== LAT) begin n_fail++;
         $display("FAIL rom_ack got=%0d exp=%0d", k, LAT); end
      n_chk++; if (rom_err !== m_rom) begin n_fail++;
         $display("FAIL rom_err_set got=%b exp=%b", rom_err, m_rom); end
      xact(1'b0, 16'h0004, 8'h00, k, dv, pv);
      m_dout = mdl_rd(16'h0004);
      n_chk++; if (dv !== m_dout) begin n_fail++;
         $display("FAIL rom_unchanged got=%h exp=%h", dv, m_dout); end
      xact(1'b1, 16'h07FF, 8'h11, k, dv, pv);
      mdl_wr(16'h07FF, 8'h11);
      xact(1'b0, 16'h0810, 8'h00, k, dv, pv);
      m_dout = mdl_rd(16'h0810);
      n_chk++; if (rom_err !== m_rom) begin n_fail++;
         $display("FAIL rom_err_sticky got=%b exp=%b", rom_err, m_rom); end
      xact(1'b0, 16'h07FF, 8'h00, k, dv, pv);
      m_dout = mdl_rd(16'h07FF);
      n_chk++; if (dv !== m_dout) begin n_fail++;
         $display("FAIL rom_top got=%h exp=%h", dv, m_dout); end
   endtask

   task automatic test_back_to_back();
      logic exp_ack;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0800; din0 = 8'h00;
      @(posedge clk);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) addr0 = 16'h0801;
         if (i == 3) addr0 = 16'h0802;
         if (i == 5) req0 = 1'b0;
         exp_ack = (i == 2 || i == 4 || i == 6);
         n_chk++; if (ack0 !== exp_ack) begin n_fail++;
            $display("FAIL b2b_ack i=%0d got=%b exp=%b", i, ack0, exp_ack); end
         if (exp_ack) begin
            n_chk++; if (dout0 !== 8'(i / 2 - 1)) begin n_fail++;
               $display("FAIL b2b_data i=%0d got=%h exp=%h",
                        i, dout0, 8'(i / 2 - 1)); end
         end
      end
   endtask

   task automatic test_busy_ignore();
      int acks = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 16'h0805;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      for (int i = 2; i <= 9; i++) begin
         @(negedge clk);
         if (i == 2) begin
            n_chk++; if (busy !== 1'b1) begin n_fail++;
               $display("FAIL busy_acc got=%b exp=1", busy); end
            req = 1'b1; addr = 16'h0806;
         end
         if (i == 3) req = 1'b0;
         if (ack) acks++;
      end
      m_dout = mdl_rd(16'h0805);
      n_chk++; if (acks !== 1) begin n_fail++;
         $display("FAIL busy_req_ignored got=%0d exp=1", acks); end
      n_chk++; if (dout !== m_dout) begin n_fail++;
         $display("FAIL busy_data got=%h exp=%h", dout, m_dout); end
   endtask

   task automatic test_reset_midop();
      int acks = 0;
      int k; logic [7:0] dv; logic pv;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 16'h0900; din = 8'h55;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      n_chk++; if (busy !== 1'b1) begin n_fail++;
         $display("FAIL mid_busy got=%b exp=1", busy); end
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      m_dout = '0; m_rom = 1'b0;
      n_chk++; if ({dout, ack, busy, rom_err, perr} !== 12'h0) begin
         n_fail++;
         $display("FAIL mid_outputs got=%h%b%b%b%b exp=0",
                  dout, ack, busy, rom_err, perr); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) acks++;
      end
      n_chk++; if (acks !== 0) begin n_fail++;
         $display("FAIL mid_no_ack got=%0d exp=0", acks); end
      xact(1'b0, 16'h0900, 8'h00, k, dv, pv);
      m_dout = mdl_rd(16'h0900);
      n_chk++; if (dv !== m_dout) begin n_fail++;
         $display("FAIL mid_no_write got=%h exp=%h", dv, m_dout); end
   endtask

   task automatic test_parity();
      int k; logic [7:0] dv; logic pv; logic pexp;
`ifdef SAP_MEM_PARITY_EN
      @(negedge clk);
      u_dut.par_q[16'h0A00] = !u_dut.par_q[16'h0A00];
      pexp = 1'b1;
      perr_exp = 1;
`else
      pexp = 1'b0;
`endif
      xact(1'b0, 16'h0A00, 8'h00, k, dv, pv);
      m_dout = mdl_rd(16'h0A00);
      n_chk++; if (pv !== pexp) begin n_fail++;
         $display("FAIL par_perr got=%b exp=%b", pv, pexp); end
      n_chk++; if (dv !== m_dout) begin n_fail++;
         $display("FAIL par_data got=%h exp=%h", dv, m_dout); end
      xact(1'b0, 16'h0A01, 8'h00, k, dv, pv);
      m_dout = mdl_rd(16'h0A01);
      n_chk++; if (pv !== 1'b0) begin n_fail++;
         $display("FAIL par_clean got=%b exp=0", pv); end
   endtask

   task automatic test_random();
      int k; logic [7:0] dv; logic pv;
      logic w; logic [15:0] a; logic [7:0] d;
      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom);
         d = 8'($urandom);
         case ($urandom % 3)
            0:       a = 16'($urandom % 16);
            1:       a = 16'h0800 + 16'($urandom % 16);
            default: a = 16'hFFF0 + 16'($urandom % 16);
         endcase
         xact(w, a, d, k, dv, pv);
         if (w) mdl_wr(a, d);
         else m_dout = mdl_rd(a);
         n_chk++; if (k !== LAT) begin n_fail++;
            $display("FAIL rnd_lat n=%0d got=%0d exp=%0d", n, k, LAT); end
         n_chk++; if (dv !== m_dout) begin n_fail++;
            $display("FAIL rnd_dout n=%0d w=%b a=%h got=%h exp=%h",
                     n, w, a, dv, m_dout); end
         n_chk++; if (rom_err !== m_rom) begin n_fail++;
            $display("FAIL rnd_rom_err n=%0d got=%b exp=%b",
                     n, rom_err, m_rom); end
      end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_ram_rw();
      test_rom_protect();
      test_back_to_back();
      test_busy_ignore();
      test_reset_midop();
      test_parity();
      test_random();
      @(negedge clk);
      n_chk++; if (perr_cnt !== perr_exp) begin n_fail++;
         $display("FAIL perr_total got=%0d exp=%0d", perr_cnt, perr_exp); end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
